// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM encoding, default
// frame geometry, and the oversample divider ratio used by the clock divider.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // clk_in cycles per oversample tick; the divider produces a 50% duty square wave
    localparam int OS_DIV_RATIO   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_tick_detect.sv
// Brings the asynchronous rx line into the clk_in domain and turns rising edges
// of the divider output into single-cycle oversample enables.
module uart_tick_detect
    import uart_pkg::*;
(
    input  logic clk_in,
    input  logic rst,
    input  logic os_clk,
    input  logic rx,
    output logic rx_s,
    output logic tick
);

    logic rx_p0;
    logic rx_p1;
    logic os_clk_d;

    // Sync flops reset to the idle level so reset release never looks like a start edge;
    // os_clk_d resets high so a divider already high at release is not counted as a tick.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            rx_p0    <= 1'b1;
            rx_p1    <= 1'b1;
            os_clk_d <= 1'b1;
        end else begin
            rx_p0    <= rx;
            rx_p1    <= rx_p0;
            os_clk_d <= os_clk;
        end
    end

    assign rx_s = rx_p1;
    assign tick = os_clk & ~os_clk_d;

endmodule

// File: rtl/uart_rx_os.sv
// 8N1-style UART receiver running on 16x oversample enables: validates the start
// bit at mid-bit, samples data LSB first, and flags framing errors with break hold-off.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE_DEF,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 os_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 tick;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_q;

    uart_tick_detect u_tick_detect (
        .clk_in (clk_in),
        .rst    (rst),
        .os_clk (os_clk),
        .rx     (rx),
        .rx_s   (rx_s),
        .tick   (tick)
    );

    // Partial byte assembly; only copied to data_out after a good stop bit.
    always_ff @(posedge clk_in) begin
        if (state == DATA && tick && cnt == CNT_LAST) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && !rx_s) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (cnt == CNT_MID) begin
                            // A line that is high again at mid start bit was a glitch.
                            state   <= rx_s ? IDLE : DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (bit_idx == BIT_LAST) begin
                                state   <= STOP;
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            if (rx_s) begin
                                data_out   <= shift_q;
                                data_valid <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Hold here while the line stays low so a break reports one error.
                    if (rx_s) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 frames on a 4-cycle oversample tick,
// glitch rejection, framing error with break, mid-frame reset, tick-at-reset.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 64;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       os_clk = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    logic [7:0] vq[$];
    logic       busy_at_valid     = 1'b1;
    logic       busy_before_valid = 1'b0;
    logic       prev_busy         = 1'b0;

    logic os_hold  = 1'b0;
    int   os_phase = 0;

    uart_rx_os #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .os_clk     (os_clk),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    // Divider model: 2 cycles high, 2 low, changing on the falling edge.
    initial forever begin
        @(negedge clk_in);
        if (os_hold) begin
            os_clk = 1'b1;
        end else begin
            os_clk   = (os_phase < 2);
            os_phase = (os_phase + 1) % 4;
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (data_valid) begin
            valid_cnt++;
            vq.push_back(data_out);
            busy_at_valid     = busy;
            busy_before_valid = prev_busy;
        end
        if (frame_err) ferr_cnt++;
        if (data_valid && frame_err) both_cnt++;
        prev_busy = busy;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        idle(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b want 0", frame_err); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", data_out); end
        rst = 1'b0;
        idle(8);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_single();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        vq.delete();
        send_frame(8'h55, 1'b1);
        idle(8);
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL single_vcount got %0d want 1", valid_cnt - v0); end
        checks++; if (vq.size() < 1 || vq[0] !== 8'h55) begin errors++; $display("FAIL single_vdata got %02h want 55", (vq.size() > 0) ? vq[0] : 8'hxx); end
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL single_data got %02h want 55", data_out); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_cnt - f0); end
        checks++; if (busy_at_valid !== 1'b0) begin errors++; $display("FAIL single_busy_at_valid got %0b want 0", busy_at_valid); end
        checks++; if (busy_before_valid !== 1'b1) begin errors++; $display("FAIL single_busy_before_valid got %0b want 1", busy_before_valid); end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        vq.delete();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(8);
        checks++; if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_vcount got %0d want 2", valid_cnt - v0); end
        checks++; if (vq.size() < 1 || vq[0] !== 8'hA3) begin errors++; $display("FAIL b2b_first got %02h want a3", (vq.size() > 0) ? vq[0] : 8'hxx); end
        checks++; if (vq.size() < 2 || vq[1] !== 8'h00) begin errors++; $display("FAIL b2b_second got %02h want 00", (vq.size() > 1) ? vq[1] : 8'hxx); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL b2b_ferr got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        rx = 1'b0;
        idle(12);
        rx = 1'b1;
        idle(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %0b want 1", busy); end
        idle(36);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %0b want 0", busy); end
        idle(BIT_CLKS);
        checks++; if (valid_cnt != v0) begin errors++; $display("FAIL glitch_valid got %0d want 0", valid_cnt - v0); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_err();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        rx = 1'b0;
        idle(BIT_CLKS * 11);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - f0); end
        checks++; if (valid_cnt != v0) begin errors++; $display("FAIL ferr_valid got %0d want 0", valid_cnt - v0); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL ferr_data got %02h want 00", data_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got %0b want 1", busy); end
        rx = 1'b1;
        idle(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got %0b want 0", busy); end
        idle(BIT_CLKS);
        send_frame(8'h3C, 1'b1);
        idle(8);
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL ferr_recover_data got %02h want 3c", data_out); end
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL ferr_recover_vcount got %0d want 1", valid_cnt - v0); end
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_recover_fcount got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_midframe();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        logic [7:0] d = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        idle(BIT_CLKS / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx  = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", data_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got %02h want 00", data_out); end
        idle(BIT_CLKS * 2);
        send_frame(8'h81, 1'b1);
        idle(8);
        checks++; if (data_out !== 8'h81) begin errors++; $display("FAIL midrst_recover_data got %02h want 81", data_out); end
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL midrst_vcount got %0d want 1", valid_cnt - v0); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL midrst_ferr got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_os_hold();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        os_hold = 1'b1;
        idle(4);
        rx  = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_tick got %0b want 0", busy); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL hold_data got %02h want 00", data_out); end
        os_hold = 1'b0;
        idle(10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_first_tick got %0b want 1", busy); end
        rx = 1'b1;
        idle(BIT_CLKS);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_false_start got %0b want 0", busy); end
        checks++; if (valid_cnt != v0 || ferr_cnt != f0) begin errors++; $display("FAIL hold_outputs got v%0d f%0d want v0 f0", valid_cnt - v0, ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_os_hold();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL valid_ferr_overlap got %0d want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
